// File: rtl/memory_multi_pkg.sv
// Shared definitions for memory_multi: RISC-V load/store funct3 codes, FSM states, access legality.
`ifndef PARAM
`define PARAM
package memory_multi_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Misalignment or a funct3 that has no meaning for the access direction.
  function automatic logic accessFault(input logic isWrite, input logic [2:0] funct3,
                                       input logic [1:0] addrLo);
    logic f;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_H:    f = addrLo[0];
      F3_W:    f = (addrLo != 2'b00);
      F3_BU:   f = isWrite;
      F3_HU:   f = isWrite | addrLo[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage
`endif

// File: rtl/memory_multi_lane_align.sv
// Byte-lane steering: store byte enables/replicated data and load extraction with sign/zero extension.
// Purely combinational, no latency, no flow control.
module mem_lane_align
  import memory_multi_pkg::*;
(
  input  logic [1:0]  iAddrLo,
  input  logic [2:0]  iFunct3,
  input  logic [31:0] iStoreData,
  input  logic [31:0] iLoadWord,
  output logic [3:0]  oByteEn,
  output logic [31:0] oStoreData,
  output logic [31:0] oLoadData
);

  logic [15:0] shifted;

  assign shifted = 16'(iLoadWord >> {iAddrLo, 3'b000});

  always_comb begin
    oByteEn    = 4'b0000;
    oStoreData = iStoreData;
    case (iFunct3)
      F3_B: begin
        oByteEn    = 4'b0001 << iAddrLo;
        oStoreData = {4{iStoreData[7:0]}};
      end
      F3_H: begin
        oByteEn    = iAddrLo[1] ? 4'b1100 : 4'b0011;
        oStoreData = {2{iStoreData[15:0]}};
      end
      F3_W:    oByteEn = 4'b1111;
      default: oByteEn = 4'b0000;
    endcase
  end

  always_comb begin
    case (iFunct3)
      F3_B:    oLoadData = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    oLoadData = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    oLoadData = iLoadWord;
      F3_BU:   oLoadData = {24'd0, shifted[7:0]};
      F3_HU:   oLoadData = {16'd0, shifted[15:0]};
      default: oLoadData = 32'd0;
    endcase
  end

endmodule

// File: rtl/memory_multi.sv
// Multicycle data memory with byte/half/word access; oReady pulses WAIT_STATES+1 cycles after accept.
// No backpressure: requests are taken only in IDLE, and held strobes are ignored until both drop.
module memory_multi
  import memory_multi_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddress,
  input  logic [31:0] iWriteData,
  input  logic [2:0]  iFunct3,
  output logic [31:0] oReadData,
  output logic        oReady,
  output logic        oBusy,
  output logic        oFault
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAST_WAIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  waitCnt;
  logic [31:0] addrQ;
  logic [31:0] dataQ;
  logic [2:0]  funct3Q;
  logic        writeQ;

  logic [31:0] mem [DEPTH_WORDS];

  logic          inIdle, oneStrobe, bothStrobes, enterResp;
  logic [31:0]   srcAddr, srcData, offset, memWord;
  logic [2:0]    srcFunct3;
  logic          srcWrite, srcFault;
  logic [3:0]    byteEn;
  logic [31:0]   storeData, loadData;
  logic [AW-1:0] wordIdx;

  // Zero-wait builds act on the request in the accept cycle, so source fields bypass the latches in IDLE.
  assign inIdle      = (state == IDLE);
  assign oneStrobe   = iMemRead ^ iMemWrite;
  assign bothStrobes = iMemRead & iMemWrite;
  assign srcAddr     = inIdle ? iAddress   : addrQ;
  assign srcData     = inIdle ? iWriteData : dataQ;
  assign srcFunct3   = inIdle ? iFunct3    : funct3Q;
  assign srcWrite    = inIdle ? iMemWrite  : writeQ;

  assign offset   = srcAddr - BASE_ADDR;
  assign srcFault = accessFault(srcWrite, srcFunct3, srcAddr[1:0])
                  | (srcAddr < BASE_ADDR)
                  | ((offset >> 2) >= 32'(DEPTH_WORDS));
  assign wordIdx  = offset[AW+1:2];
  assign memWord  = mem[wordIdx];

  assign enterResp = ~iRST & ((inIdle & oneStrobe & (WAIT_STATES == 0))
                            | ((state == WAIT) & (waitCnt == LAST_WAIT)));

  mem_lane_align uLane (
    .iAddrLo    (srcAddr[1:0]),
    .iFunct3    (srcFunct3),
    .iStoreData (srcData),
    .iLoadWord  (memWord),
    .oByteEn    (byteEn),
    .oStoreData (storeData),
    .oLoadData  (loadData)
  );

  // Storage is intentionally outside reset so an aborted request never disturbs contents.
  always_ff @(posedge iCLK) begin
    if (enterResp && srcWrite && !srcFault) begin
      for (int i = 0; i < 4; i++) begin
        if (byteEn[i]) mem[wordIdx][8*i +: 8] <= storeData[8*i +: 8];
      end
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      waitCnt   <= 4'd0;
      addrQ     <= 32'd0;
      dataQ     <= 32'd0;
      funct3Q   <= 3'd0;
      writeQ    <= 1'b0;
      oReadData <= 32'd0;
      oReady    <= 1'b0;
      oBusy     <= 1'b0;
      oFault    <= 1'b0;
    end else begin
      oReady <= 1'b0;
      oFault <= 1'b0;
      case (state)
        IDLE: begin
          if (bothStrobes) begin
            state     <= RESP;
            oBusy     <= 1'b1;
            oReady    <= 1'b1;
            oFault    <= 1'b1;
            oReadData <= 32'd0;
          end else if (oneStrobe) begin
            addrQ   <= iAddress;
            dataQ   <= iWriteData;
            funct3Q <= iFunct3;
            writeQ  <= iMemWrite;
            waitCnt <= 4'd0;
            oBusy   <= 1'b1;
            state   <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (waitCnt == LAST_WAIT) state <= RESP;
          else waitCnt <= waitCnt + 4'd1;
        end
        RESP: state <= HOLD;
        HOLD: begin
          if (!iMemRead && !iMemWrite) begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
      if (enterResp) begin
        oReady <= 1'b1;
        oFault <= srcFault;
        if (srcFault) oReadData <= 32'd0;
        else if (!srcWrite) oReadData <= loadData;
      end
    end
  end

endmodule
